// File: rtl/barrett_reduce_multi_pkg.sv
// Per-scheme Barrett constants for the Dilithium and Kyber moduli, plus a lookup helper.
// Latency: none; this is a package of constants and a pure function.
// Backpressure: not applicable.
package barrett_reduce_multi_pkg;

  typedef enum logic {
    SCHEME_DILITHIUM = 1'b0,
    SCHEME_KYBER     = 1'b1
  } scheme_e;

  localparam int Q_W   = 24;
  localparam int K_W   = 6;
  localparam int MU_W  = 24;
  localparam int QSQ_W = 48;

  localparam logic [Q_W-1:0]   MODULUS_DILITHIUM        = 24'd8380417;
  localparam logic [K_W-1:0]   MODULUS_LENGTH_DILITHIUM = 6'd23;
  localparam logic [MU_W-1:0]  MU_DILITHIUM             = 24'd8396807;
  localparam logic [QSQ_W-1:0] MODULUS_SQ_DILITHIUM     = 48'd70231389093889;

  localparam logic [Q_W-1:0]   MODULUS_KYBER            = 24'd3329;
  localparam logic [K_W-1:0]   MODULUS_LENGTH_KYBER     = 6'd12;
  localparam logic [MU_W-1:0]  MU_KYBER                 = 24'd5039;
  localparam logic [QSQ_W-1:0] MODULUS_SQ_KYBER         = 48'd11082241;

  typedef struct packed {
    logic [Q_W-1:0]   q;
    logic [K_W-1:0]   k;
    logic [MU_W-1:0]  mu;
    logic [QSQ_W-1:0] q_sq;
  } const_t;

  function automatic const_t get_consts(scheme_e scheme);
    const_t c;
    if (scheme == SCHEME_KYBER) begin
      c.q    = MODULUS_KYBER;
      c.k    = MODULUS_LENGTH_KYBER;
      c.mu   = MU_KYBER;
      c.q_sq = MODULUS_SQ_KYBER;
    end else begin
      c.q    = MODULUS_DILITHIUM;
      c.k    = MODULUS_LENGTH_DILITHIUM;
      c.mu   = MU_DILITHIUM;
      c.q_sq = MODULUS_SQ_DILITHIUM;
    end
    return c;
  endfunction

endpackage

// File: rtl/barrett_reduce_multi_const_sel.sv
// Maps the per-transaction scheme select to its {q, k, mu, q^2} constant set.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result alongside its transaction.
module barrett_const_sel
  import barrett_reduce_multi_pkg::*;
(
  input  scheme_e mode_i,
  output const_t  const_o
);

  // Constant lookup for the selected scheme.
  always_comb begin
    const_o = get_consts(mode_i);
  end

endmodule

// File: rtl/barrett_reduce_multi.sv
// Four-stage Barrett reduction of x < q^2 modulo a per-transaction Dilithium or Kyber q.
// Latency: 4 cycles from input transfer to out_valid_o; one result per cycle at full rate.
// Backpressure: out_ready_i low holds S4 and ripples combinationally to in_ready_o; empty stages still fill.
module barrett_reduce_multi
  import barrett_reduce_multi_pkg::*;
#(
  parameter int LENGTH = 64,
  parameter int TAG_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [LENGTH-1:0] in_data_i,
  input  logic              in_mode_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [LENGTH-1:0] out_data_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic              out_err_o
);

  const_t sel_c;

  barrett_const_sel u_const_sel (
    .mode_i (scheme_e'(in_mode_i)),
    .const_o(sel_c)
  );

  // S1: raw operand, tag, range flag and the constants the later stages need
  logic              s1_vld_q, s1_vld_d, s1_err_q, s1_err_d;
  logic [LENGTH-1:0] s1_x_q, s1_x_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [Q_W-1:0]    s1_q_q, s1_q_d;
  logic [K_W-1:0]    s1_k_q, s1_k_d;
  logic [MU_W-1:0]   s1_mu_q, s1_mu_d;
  // S2: quotient estimate
  logic              s2_vld_q, s2_vld_d, s2_err_q, s2_err_d;
  logic [LENGTH-1:0] s2_x_q, s2_x_d, s2_qhat_q, s2_qhat_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
  logic [Q_W-1:0]    s2_q_q, s2_q_d;
  logic [K_W-1:0]    s2_k_q, s2_k_d;
  // S3: partial remainder in [0, 3q)
  logic              s3_vld_q, s3_vld_d, s3_err_q, s3_err_d;
  logic [LENGTH-1:0] s3_r_q, s3_r_d;
  logic [TAG_W-1:0]  s3_tag_q, s3_tag_d;
  logic [Q_W-1:0]    s3_q_q, s3_q_d;
  // S4: final result, drives the output port
  logic              s4_vld_q, s4_vld_d, s4_err_q, s4_err_d;
  logic [LENGTH-1:0] s4_data_q, s4_data_d;
  logic [TAG_W-1:0]  s4_tag_q, s4_tag_d;

  logic s1_acc, s2_acc, s3_acc, s4_acc;
  logic [LENGTH-1:0] s2_t, s2_qhat, s3_prod, s3_r, s4_q, s4_two_q, s4_r;

  // Each stage takes a new entry when it is empty or its content moves on.
  always_comb begin
    s4_acc = !s4_vld_q || out_ready_i;
    s3_acc = !s3_vld_q || s4_acc;
    s2_acc = !s2_vld_q || s3_acc;
    s1_acc = !s1_vld_q || s2_acc;
  end

  assign in_ready_o  = s1_acc;
  assign out_valid_o = s4_vld_q;
  assign out_data_o  = s4_data_q;
  assign out_tag_o   = s4_tag_q;
  assign out_err_o   = s4_err_q;

  // Barrett arithmetic: quotient estimate, remainder mod 2^(k+2), final correction.
  always_comb begin
    s2_t     = (s1_x_q >> (s1_k_q - K_W'(1))) * LENGTH'(s1_mu_q);
    s2_qhat  = s2_t >> (s1_k_q + K_W'(1));
    s3_prod  = s2_qhat_q * LENGTH'(s2_q_q);
    s3_r     = (s2_x_q - s3_prod) & ((LENGTH'(1) << (s2_k_q + K_W'(2))) - LENGTH'(1));
    s4_q     = LENGTH'(s3_q_q);
    s4_two_q = s4_q << 1;
    if (s3_r_q >= s4_two_q) begin
      s4_r = s3_r_q - s4_two_q;
    end else if (s3_r_q >= s4_q) begin
      s4_r = s3_r_q - s4_q;
    end else begin
      s4_r = s3_r_q;
    end
  end

  // Stage next-state: hold by default, load from the upstream stage when accepting.
  always_comb begin
    s1_vld_d = s1_vld_q; s1_err_d = s1_err_q; s1_x_d = s1_x_q; s1_tag_d = s1_tag_q;
    s1_q_d = s1_q_q; s1_k_d = s1_k_q; s1_mu_d = s1_mu_q;
    s2_vld_d = s2_vld_q; s2_err_d = s2_err_q; s2_x_d = s2_x_q; s2_tag_d = s2_tag_q;
    s2_q_d = s2_q_q; s2_k_d = s2_k_q; s2_qhat_d = s2_qhat_q;
    s3_vld_d = s3_vld_q; s3_err_d = s3_err_q; s3_r_d = s3_r_q; s3_tag_d = s3_tag_q;
    s3_q_d = s3_q_q;
    s4_vld_d = s4_vld_q; s4_err_d = s4_err_q; s4_data_d = s4_data_q; s4_tag_d = s4_tag_q;
    if (s1_acc) begin
      s1_vld_d = in_valid_i;
      s1_x_d   = in_data_i;
      s1_tag_d = in_tag_i;
      s1_err_d = in_data_i >= LENGTH'(sel_c.q_sq);
      s1_q_d   = sel_c.q;
      s1_k_d   = sel_c.k;
      s1_mu_d  = sel_c.mu;
    end
    if (s2_acc) begin
      s2_vld_d  = s1_vld_q;
      s2_err_d  = s1_err_q;
      s2_x_d    = s1_x_q;
      s2_tag_d  = s1_tag_q;
      s2_q_d    = s1_q_q;
      s2_k_d    = s1_k_q;
      s2_qhat_d = s2_qhat;
    end
    if (s3_acc) begin
      s3_vld_d = s2_vld_q;
      s3_err_d = s2_err_q;
      s3_r_d   = s3_r;
      s3_tag_d = s2_tag_q;
      s3_q_d   = s2_q_q;
    end
    if (s4_acc) begin
      s4_vld_d  = s3_vld_q;
      s4_err_d  = s3_err_q;
      s4_data_d = s3_err_q ? '0 : s4_r;
      s4_tag_d  = s3_tag_q;
    end
  end

  // Pipeline registers; reset drops every in-flight transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q <= 1'b0; s1_err_q <= 1'b0; s1_x_q <= '0; s1_tag_q <= '0;
      s1_q_q <= '0; s1_k_q <= '0; s1_mu_q <= '0;
      s2_vld_q <= 1'b0; s2_err_q <= 1'b0; s2_x_q <= '0; s2_tag_q <= '0;
      s2_q_q <= '0; s2_k_q <= '0; s2_qhat_q <= '0;
      s3_vld_q <= 1'b0; s3_err_q <= 1'b0; s3_r_q <= '0; s3_tag_q <= '0; s3_q_q <= '0;
      s4_vld_q <= 1'b0; s4_err_q <= 1'b0; s4_data_q <= '0; s4_tag_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d; s1_err_q <= s1_err_d; s1_x_q <= s1_x_d; s1_tag_q <= s1_tag_d;
      s1_q_q <= s1_q_d; s1_k_q <= s1_k_d; s1_mu_q <= s1_mu_d;
      s2_vld_q <= s2_vld_d; s2_err_q <= s2_err_d; s2_x_q <= s2_x_d; s2_tag_q <= s2_tag_d;
      s2_q_q <= s2_q_d; s2_k_q <= s2_k_d; s2_qhat_q <= s2_qhat_d;
      s3_vld_q <= s3_vld_d; s3_err_q <= s3_err_d; s3_r_q <= s3_r_d; s3_tag_q <= s3_tag_d;
      s3_q_q <= s3_q_d;
      s4_vld_q <= s4_vld_d; s4_err_q <= s4_err_d; s4_data_q <= s4_data_d; s4_tag_q <= s4_tag_d;
    end
  end

endmodule

// File: tb/tb_barrett_reduce_multi.sv
// Testbench for barrett_reduce_multi: directed cases plus a randomized mixed-scheme stream.
// Expected results come from plain modular arithmetic kept in an in-order queue.
// Backpressure is exercised both held-low and randomized.
module tb_barrett_reduce_multi;

  localparam int LENGTH = 64;
  localparam int TAG_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [LENGTH-1:0] in_data = '0;
  logic              in_mode = 1'b0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [LENGTH-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  logic              drv_lit = 1'b0;
  logic [63:0]       drv_ld = '0;
  logic              drv_le = 1'b0;

  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned stall_cnt = 0;
  int unsigned acc_cnt = 0;
  int          rdy_mode = 0;
  int unsigned gap_pct = 0;

  always #5 clk = ~clk;

  barrett_reduce_multi #(.LENGTH(LENGTH), .TAG_W(TAG_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_mode_i  (in_mode),
    .in_tag_i   (in_tag),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_tag_o  (out_tag),
    .out_err_o  (out_err)
  );

  typedef struct {
    logic [63:0] x;
    logic        m;
    logic [3:0]  tag;
    logic        lit;
    logic [63:0] ld;
    logic        le;
  } drv_t;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    logic        err;
    int unsigned t_in;
    int unsigned stalls;
    logic        lit;
    logic [63:0] ld;
    logic        le;
  } exp_t;

  drv_t dq[$];
  exp_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: x mod q, or error with zero data when x >= q^2.
  function automatic void ref_model(input logic [63:0] x, input logic m,
                                    output logic [63:0] r, output logic e);
    logic [63:0] q;
    q = m ? 64'd3329 : 64'd8380417;
    e = (x >= q * q);
    r = e ? 64'd0 : x % q;
  endfunction

  // Compare process: in-order scoreboard, stall stability and latency.
  logic        hold = 1'b0;
  logic [63:0] h_data;
  logic [3:0]  h_tag;
  logic        h_err;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      mq.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", out_data, h_data);
        chk("stall_tag", 64'(out_tag), 64'(h_tag));
        chk("stall_err", 64'(out_err), 64'(h_err));
      end
      hold = 1'b0;
      if (out_valid) begin
        if (mq.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'd0);
        end else if (out_ready) begin
          e = mq.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_tag", 64'(out_tag), 64'(e.tag));
          chk("out_err", 64'(out_err), 64'(e.err));
          if (e.lit) begin
            chk("lit_data", out_data, e.ld);
            chk("lit_err", 64'(out_err), 64'(e.le));
          end
          if (e.stalls == stall_cnt) chk("latency", 64'(cyc - e.t_in), 64'd4);
        end else begin
          hold   = 1'b1;
          h_data = out_data;
          h_tag  = out_tag;
          h_err  = out_err;
        end
      end
      if (!out_ready) stall_cnt++;
      if (in_valid && in_ready) begin
        ref_model(in_data, in_mode, e.data, e.err);
        e.tag    = in_tag;
        e.t_in   = cyc;
        e.stalls = stall_cnt;
        e.lit    = drv_lit;
        e.ld     = drv_ld;
        e.le     = drv_le;
        mq.push_back(e);
      end
    end
  end

  task automatic push(input logic [63:0] x, input logic m, input logic [3:0] tag,
                      input logic lit, input logic [63:0] ld, input logic le);
    drv_t d;
    d.x = x; d.m = m; d.tag = tag; d.lit = lit; d.ld = ld; d.le = le;
    dq.push_back(d);
  endtask

  task automatic tick();
    @(negedge clk);
    if (!rst && in_valid && in_ready) begin
      void'(dq.pop_front());
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(3) != 0);
    endcase
    if (!rst && dq.size() > 0 && $urandom_range(99) >= gap_pct) begin
      in_valid = 1'b1;
      in_data  = dq[0].x;
      in_mode  = dq[0].m;
      in_tag   = dq[0].tag;
      drv_lit  = dq[0].lit;
      drv_ld   = dq[0].ld;
      drv_le   = dq[0].le;
    end else begin
      in_valid = 1'b0;
      drv_lit  = 1'b0;
    end
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((dq.size() > 0 || mq.size() > 0) && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(dq.size() + mq.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    drv_lit  = 1'b0;
    dq.delete();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] r;
    logic        e;
    logic [63:0] x;
    logic [63:0] q;
    logic        m;
    int unsigned sel;

    // Hand-computed values pinning the reference model.
    ref_model(64'd41902092, 1'b0, r, e);        chk("model_5q_plus_7", r, 64'd7);
    ref_model(64'd70231372333056, 1'b0, r, e);  chk("model_dil_qm1_sq", r, 64'd1);
    ref_model(64'd11075584, 1'b1, r, e);        chk("model_kyb_qm1_sq", r, 64'd1);
    ref_model(64'd70231389093889, 1'b0, r, e);  chk("model_dil_err", 64'(e), 64'd1);
    ref_model(64'd11082240, 1'b1, r, e);        chk("model_kyb_max", r, 64'd3328);

    rdy_mode = 0;
    do_reset();

    // Basic Dilithium case with latency.
    push(64'd41902092, 1'b0, 4'd3, 1'b1, 64'd7, 1'b0);
    drain(50);

    // Back-to-back Dilithium.
    push(64'd70231372333056, 1'b0, 4'd1, 1'b1, 64'd1, 1'b0);
    push(64'd0,              1'b0, 4'd2, 1'b1, 64'd0, 1'b0);
    push(64'd8380417,        1'b0, 4'd4, 1'b1, 64'd0, 1'b0);
    drain(50);

    // Interleaved schemes.
    push(64'd11075584, 1'b1, 4'd5, 1'b1, 64'd1, 1'b0);
    push(64'd8380418,  1'b0, 4'd6, 1'b1, 64'd1, 1'b0);
    push(64'd11075584, 1'b1, 4'd7, 1'b1, 64'd1, 1'b0);
    push(64'd8380418,  1'b0, 4'd8, 1'b1, 64'd1, 1'b0);
    drain(50);

    // Range boundaries.
    push(64'd70231389093889, 1'b0, 4'd9,  1'b1, 64'd0,    1'b1);
    push(64'd11082241,       1'b1, 4'd10, 1'b1, 64'd0,    1'b1);
    push(64'd11082240,       1'b1, 4'd11, 1'b1, 64'd3328, 1'b0);
    push(64'd70231389093888, 1'b0, 4'd12, 1'b1, 64'd8380416, 1'b0);
    drain(50);

    // Held backpressure: exactly four fit.
    rdy_mode  = 1;
    out_ready = 1'b0;
    acc_cnt   = 0;
    for (int i = 0; i < 6; i++) begin
      m = 1'($urandom_range(1));
      q = m ? 64'd3329 : 64'd8380417;
      push({$urandom, $urandom} % (q * q), m, 4'(i), 1'b0, 64'd0, 1'b0);
    end
    repeat (10) tick();
    chk("bp_accepted", 64'(acc_cnt), 64'd4);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    rdy_mode = 0;
    drain(100);

    // Reset with three transactions in flight.
    acc_cnt = 0;
    push(64'd100, 1'b0, 4'd1, 1'b0, 64'd0, 1'b0);
    push(64'd200, 1'b1, 4'd2, 1'b0, 64'd0, 1'b0);
    push(64'd300, 1'b0, 4'd3, 1'b0, 64'd0, 1'b0);
    repeat (4) tick();
    chk("mid_accepted", 64'(acc_cnt), 64'd3);
    chk("mid_pending", 64'(mq.size()), 64'd3);
    do_reset();
    repeat (8) tick();
    push(64'd41902092, 1'b0, 4'd13, 1'b1, 64'd7, 1'b0);
    drain(50);

    // Randomized mixed-scheme stream with random gaps and backpressure.
    rdy_mode = 2;
    gap_pct  = 25;
    for (int i = 0; i < 400; i++) begin
      m   = 1'($urandom_range(1));
      q   = m ? 64'd3329 : 64'd8380417;
      sel = $urandom_range(9);
      if (sel == 0)      x = {$urandom, $urandom};
      else if (sel == 1) x = q * q - 64'($urandom_range(2));
      else               x = {$urandom, $urandom} % (q * q);
      push(x, m, 4'(i), 1'b0, 64'd0, 1'b0);
    end
    drain(5000);
    rdy_mode = 0;
    gap_pct  = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
